// File: rtl/credit_sender.sv
// credit_sender: credit-based transmitter feeding a remote val/rdy queue over a
// registered link. Upstream is val/rdy; downstream sees only registered
// send_val/send_msg, throttled by a local credit counter that is preloaded to
// the remote queue depth and replenished by one-cycle credit_in pulses.
// A RUN/DRAIN/DONE FSM lets the owner flush: stop accepting, wait until every
// credit is back and the link is idle, then pulse flush_done.
//
// Optional build macro: CREDIT_SENDER_STATS_EN adds stall_cnt and sent_cnt.

module credit_sender #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CREDITS = 16,
  localparam int unsigned CNT_W  = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] recv_msg,
  input  logic             recv_val,
  output logic             recv_rdy,
  output logic [WIDTH-1:0] send_msg,
  output logic             send_val,
  input  logic             credit_in,
  input  logic             flush,
  output logic             flush_done,
  output logic [CNT_W-1:0] credit_cnt,
  output logic             credit_err
`ifdef CREDIT_SENDER_STATS_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      sent_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             err_nxt;
  logic             send_val_nxt;
  logic [WIDTH-1:0] send_msg_nxt;
  logic             flush_done_nxt;
  logic             accept;
  logic             link_idle;

  // Ready is taken from the registered count, so a returned credit at zero
  // only opens the gate on the following cycle.
  assign recv_rdy  = (state == ST_RUN) && (credit_cnt != '0);
  assign accept    = recv_val && recv_rdy;
  assign link_idle = (credit_cnt == CNT_FULL) && !send_val;

  // Credit counter: simultaneous spend and return cancel; a return at full is an error.
  always_comb begin
    cnt_nxt = credit_cnt;
    err_nxt = credit_err;
    unique case ({accept, credit_in})
      2'b10: cnt_nxt = credit_cnt - CNT_ONE;
      2'b01: begin
        if (credit_cnt == CNT_FULL) begin
          err_nxt = 1'b1;
        end else begin
          cnt_nxt = credit_cnt + CNT_ONE;
        end
      end
      default: cnt_nxt = credit_cnt;
    endcase
  end

  // Next state and next registered outputs.
  always_comb begin
    state_nxt      = state;
    send_val_nxt   = accept;
    send_msg_nxt   = accept ? recv_msg : send_msg;
    flush_done_nxt = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (flush) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (link_idle) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
    flush_done_nxt = (state_nxt == ST_DONE);
  end

  // State and output registers; reset drops any in-flight message.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_RUN;
      credit_cnt <= CNT_FULL;
      credit_err <= 1'b0;
      send_val   <= 1'b0;
      send_msg   <= '0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      credit_cnt <= cnt_nxt;
      credit_err <= err_nxt;
      send_val   <= send_val_nxt;
      send_msg   <= send_msg_nxt;
      flush_done <= flush_done_nxt;
    end
  end

`ifdef CREDIT_SENDER_STATS_EN
  logic stall;

  // A stall is upstream offering data in RUN while out of credits.
  assign stall = recv_val && !recv_rdy && (state == ST_RUN);

  // Free-running statistics counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      sent_cnt  <= '0;
    end else begin
      if (stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (accept) begin
        sent_cnt <= sent_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_credit_sender.sv
// Bench for credit_sender: directed scenarios followed by random traffic,
// checked by a scoreboard against a transaction-level credit/flush model.
module tb_credit_sender;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned CREDITS = 16;
  localparam int unsigned CNT_W   = $clog2(CREDITS + 1);

  localparam int MODE_RUN   = 0;
  localparam int MODE_DRAIN = 1;
  localparam int MODE_DONE  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] recv_msg;
  logic             recv_val;
  logic             recv_rdy;
  logic [WIDTH-1:0] send_msg;
  logic             send_val;
  logic             credit_in;
  logic             flush;
  logic             flush_done;
  logic [CNT_W-1:0] credit_cnt;
  logic             credit_err;
`ifdef CREDIT_SENDER_STATS_EN
  logic [31:0]      stall_cnt;
  logic [31:0]      sent_cnt;
`endif

  credit_sender #(.WIDTH(WIDTH), .CREDITS(CREDITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .recv_msg   (recv_msg),
    .recv_val   (recv_val),
    .recv_rdy   (recv_rdy),
    .send_msg   (send_msg),
    .send_val   (send_val),
    .credit_in  (credit_in),
    .flush      (flush),
    .flush_done (flush_done),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
`ifdef CREDIT_SENDER_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .sent_cnt   (sent_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (values as seen between clock edges).
  int               m_cred;
  bit               m_err;
  int               m_mode;
  bit               m_sent_last;
  bit               m_fd;
  logic [WIDTH-1:0] m_last_msg;
  logic [WIDTH-1:0] exp_q[$];
  bit [31:0]        m_stall;
  bit [31:0]        m_sent;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: one transaction-level step per clock edge, from the rules of the block.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cred      = CREDITS;
      m_err       = 1'b0;
      m_mode      = MODE_RUN;
      m_sent_last = 1'b0;
      m_fd        = 1'b0;
      m_last_msg  = '0;
      m_stall     = '0;
      m_sent      = '0;
      exp_q.delete();
    end else begin
      bit rdy;
      bit acc;
      bit drained;
      rdy     = (m_mode == MODE_RUN) && (m_cred > 0);
      acc     = recv_val && rdy;
      drained = (m_cred == CREDITS) && !m_sent_last;
      if (recv_val && !rdy && m_mode == MODE_RUN) m_stall++;
      if (acc) begin
        exp_q.push_back(recv_msg);
        m_sent++;
      end
      if (acc && !credit_in) m_cred--;
      else if (credit_in && !acc) begin
        if (m_cred == CREDITS) m_err = 1'b1;
        else m_cred++;
      end
      case (m_mode)
        MODE_RUN:   if (flush) m_mode = MODE_DRAIN;
        MODE_DRAIN: if (drained) m_mode = MODE_DONE;
        default:    m_mode = MODE_RUN;
      endcase
      m_fd        = (m_mode == MODE_DONE);
      m_sent_last = acc;
    end
  end

  // Monitor: compare DUT against the model mid-cycle.
  always @(negedge clk) begin
    chk("recv_rdy", recv_rdy, (m_mode == MODE_RUN && m_cred > 0) ? 1 : 0);
    chk("credit_cnt", credit_cnt, m_cred);
    chk("credit_err", credit_err, m_err);
    chk("flush_done", flush_done, m_fd);
    chk("send_val", send_val, (exp_q.size() > 0) ? 1 : 0);
    if (exp_q.size() > 0) begin
      logic [WIDTH-1:0] e;
      e = exp_q.pop_front();
      if (send_val) chk("send_msg", send_msg, e);
      m_last_msg = e;
    end else begin
      chk("send_msg_hold", send_msg, m_last_msg);
    end
`ifdef CREDIT_SENDER_STATS_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("sent_cnt", sent_cnt, m_sent);
`endif
  end

  task automatic step(input logic v, input logic [WIDTH-1:0] m, input logic c, input logic f);
    recv_val  = v;
    recv_msg  = m;
    credit_in = c;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    recv_val  = 1'b0;
    recv_msg  = '0;
    credit_in = 1'b0;
    flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Burst until credits run out, then keep offering.
    for (int i = 1; i <= 16; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h12, 1'b0, 1'b0);

    // One credit back at zero: ready opens the next cycle.
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // At five credits, spend and return together.
    repeat (5) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Refill, then over-return to raise the sticky error.
    for (int k = 0; k < 40 && m_cred < CREDITS; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Flush with traffic outstanding; a second flush during drain is ignored.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h30 + WIDTH'(i), 1'b0, 1'b0);
    step(1'b1, 8'h40, 1'b0, 1'b1);
    for (int k = 0; k < 30; k++)
      step(1'b1, 8'h50 + WIDTH'(k), (k % 2 == 0) && (m_cred < CREDITS), k == 3);

    // Flush from an idle, full link.
    for (int k = 0; k < 40 && m_cred < CREDITS; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (4) step(1'b1, 8'h66, 1'b0, 1'b0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic v;
      logic c;
      logic f;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 9) < 4) && ((m_cred < CREDITS) || ($urandom_range(0, 199) == 0));
      f = ($urandom_range(0, 63) == 0);
      step(v, WIDTH'($urandom), c, f);
    end

    // Clean reset, raise error, spend 9 credits, then reset mid-stream.
    reset = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 8'h70 + WIDTH'(i), 1'b0, 1'b0);
    chk("pre_reset_credit_cnt", credit_cnt, 7);
    chk("pre_reset_send_val", send_val, 1);
    chk("pre_reset_credit_err", credit_err, 1);
    reset = 1'b0;
    #1;
    chk("async_reset_send_val", send_val, 0);
    chk("async_reset_credit_cnt", credit_cnt, CREDITS);
    chk("async_reset_credit_err", credit_err, 0);
`ifdef CREDIT_SENDER_STATS_EN
    chk("async_reset_stall_cnt", stall_cnt, 0);
    chk("async_reset_sent_cnt", sent_cnt, 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 8'h90 + WIDTH'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
